fetch_unit: RTL

- Parametrised instruction-fetch front end for the Fetch stage; successor to the single-word fetch step.
- Owns the program counter and issues pipelined, in-order requests to instruction memory over a valid/ready request channel with a separate response channel.
- Buffers returned instructions with their PCs in a BUF_DEPTH-entry prefetch queue and presents them to Decode over a valid/ready handshake.
- Supports redirect (branch/jump/trap): flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues pipelined memory requests
// and buffers returned words with their PCs in a prefetch queue for Decode.
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter int              BUF_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_step_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_adres_o,
  input  logic            mem_resp_valid_i,
  input  logic [XLEN-1:0] mem_resp_data_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] instruction_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(BUF_DEPTH);

  logic [XLEN-1:0]      fetch_pc;
  logic [XLEN-1:0]      pc_q   [BUF_DEPTH];
  logic [XLEN-1:0]      data_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] filled;
  logic [PW-1:0]        head;
  logic [PW-1:0]        fill;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        occ;
  logic [CW-1:0]        pend;
  logic [CW-1:0]        drop_cnt;
  logic [CW:0]          used;
  logic                 req_fire;
  logic                 pop_fire;
  logic                 resp_live;
  logic                 unused_low;

  assign unused_low = ^redirect_pc_i[1:0];

  // In-flight responses owed to a flushed queue still hold credit.
  assign used = {1'b0, occ} + {1'b0, drop_cnt};

  assign mem_req_valid_o = rst_i & enable_step_i
                         & ~redirect_valid_i & (used < CAP);
  assign mem_adres_o     = fetch_pc;

  assign inst_valid_o  = filled[head] & ~redirect_valid_i;
  assign instruction_o = data_q[head];
  assign inst_pc_o     = pc_q[head];

  assign req_fire  = mem_req_valid_o & mem_req_ready_i;
  assign pop_fire  = inst_valid_o & inst_ready_i;
  assign resp_live = mem_resp_valid_i & (drop_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      occ      <= '0;
      pend     <= '0;
      drop_cnt <= '0;
      filled   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (redirect_valid_i) begin
      fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      occ      <= '0;
      pend     <= '0;
      filled   <= '0;
      drop_cnt <= drop_cnt + pend - CW'(mem_resp_valid_i);
    end else begin
      if (req_fire) begin
        pc_q[tail] <= fetch_pc;
        tail       <= tail + 1'b1;
        fetch_pc   <= fetch_pc + XLEN'(4);
      end
      if (pop_fire) begin
        filled[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (mem_resp_valid_i) begin
        if (drop_cnt != '0) begin
          drop_cnt <= drop_cnt - 1'b1;
        end else begin
          data_q[fill] <= mem_resp_data_i;
          filled[fill] <= 1'b1;
          fill         <= fill + 1'b1;
        end
      end
      occ  <= occ + CW'(req_fire) - CW'(pop_fire);
      pend <= pend + CW'(req_fire) - CW'(resp_live);
    end
  end

endmodule
